// File: rtl/swirl_pkg.sv
// Shared types and helpers for the GEMM operand feeder and its neighbours.
package swirl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } feeder_state_e;

    localparam logic [4:0] BITSIZE_2  = 5'd2;
    localparam logic [4:0] BITSIZE_4  = 5'd4;
    localparam logic [4:0] BITSIZE_8  = 5'd8;
    localparam logic [4:0] BITSIZE_16 = 5'd16;

    // A precision is usable only if it is one of the supported sizes and fits the datapath.
    function automatic logic is_legal_bitsize(input logic [4:0] bit_size, input int max_width);
        logic known;
        known = (bit_size == BITSIZE_2) || (bit_size == BITSIZE_4) ||
                (bit_size == BITSIZE_8) || (bit_size == BITSIZE_16);
        return known && (int'(bit_size) <= max_width);
    endfunction

endpackage

// File: rtl/tile_index_counter.sv
// Row-major (i, j) walker over an M x N tile; wraps to (0, 0) after the last element.
module tile_index_counter #(
    parameter int M  = 2,
    parameter int N  = 2,
    parameter int IW = (M > 1) ? $clog2(M) : 1,
    parameter int JW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          advance_i,
    output logic [IW-1:0] idx_i_o,
    output logic [JW-1:0] idx_j_o,
    output logic          last_o
);

    logic [IW-1:0] i_q, i_d;
    logic [JW-1:0] j_q, j_d;
    logic          i_last, j_last;

    assign i_last = (i_q == IW'(M - 1));
    assign j_last = (j_q == JW'(N - 1));

    // A size-1 dimension is always "last", so its index never leaves 0.
    always_comb begin
        i_d = i_q;
        j_d = j_q;
        if (clear_i) begin
            i_d = '0;
            j_d = '0;
        end else if (advance_i) begin
            if (j_last) begin
                j_d = '0;
                i_d = i_last ? '0 : i_q + IW'(1);
            end else begin
                j_d = j_q + JW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            i_q <= '0;
            j_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
        end
    end

    assign idx_i_o = i_q;
    assign idx_j_o = j_q;
    assign last_o  = i_last && j_last;

endmodule

// File: rtl/gemm_operand_feeder.sv
// Latches A/B/C tiles on start and streams one output element's operands per transfer,
// row-major over the C tile, ending with a one-cycle done pulse.
module gemm_operand_feeder
    import swirl_pkg::*;
#(
    parameter int M         = 2,
    parameter int N         = 2,
    parameter int K         = 2,
    parameter int MAX_WIDTH = 16,
    localparam int IW = (M > 1) ? $clog2(M) : 1,
    localparam int JW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   start_i,
    output logic                                   start_ready_o,
    input  logic [4:0]                             bitSize_i,
    input  logic [M-1:0][K-1:0][MAX_WIDTH-1:0]     A_i,
    input  logic [K-1:0][N-1:0][MAX_WIDTH-1:0]     B_i,
    input  logic [M-1:0][N-1:0][2*MAX_WIDTH-1:0]   C_i,
    input  logic                                   flush_i,
    output logic [K-1:0][MAX_WIDTH-1:0]            row_o,
    output logic [K-1:0][MAX_WIDTH-1:0]            column_o,
    output logic [2*MAX_WIDTH-1:0]                 C_o,
    output logic [4:0]                             bitSize_o,
    output logic [IW-1:0]                          idx_i_o,
    output logic [JW-1:0]                          idx_j_o,
    output logic                                   valid_o,
    input  logic                                   ready_i,
    output logic                                   done_o,
    output logic                                   err_o,
    output logic [1:0]                             state_o
);

    feeder_state_e state_q, state_d;

    logic [M-1:0][K-1:0][MAX_WIDTH-1:0]   a_q;
    logic [K-1:0][N-1:0][MAX_WIDTH-1:0]   b_q;
    logic [M-1:0][N-1:0][2*MAX_WIDTH-1:0] c_q;
    logic [4:0]                           bitsize_q;
    logic                                 err_q, err_d;

    logic start_fire, load, xfer, flushing, last_elem;

    // Handshake: a transfer happens on any cycle with valid_o && ready_i; once valid_o
    // rises, it and all operand outputs hold until that transfer (or a flush/reset).
    assign start_ready_o = (state_q == ST_IDLE);
    assign valid_o       = (state_q == ST_ISSUE);
    assign done_o        = (state_q == ST_DONE);
    assign err_o         = err_q;
    assign bitSize_o     = bitsize_q;
    assign state_o       = state_q;

    assign start_fire = start_i && start_ready_o;
    assign load       = start_fire && is_legal_bitsize(bitSize_i, MAX_WIDTH);
    assign err_d      = start_fire && !is_legal_bitsize(bitSize_i, MAX_WIDTH);
    assign xfer       = valid_o && ready_i;
    assign flushing   = flush_i && (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (load) state_d = ST_ISSUE;
            ST_ISSUE: begin
                if (flushing)               state_d = ST_IDLE;
                else if (xfer && last_elem) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    tile_index_counter #(
        .M (M),
        .N (N),
        .IW(IW),
        .JW(JW)
    ) u_index (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (load || flushing),
        .advance_i(xfer),
        .idx_i_o  (idx_i_o),
        .idx_j_o  (idx_j_o),
        .last_o   (last_elem)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            err_q     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            bitsize_q <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (load) begin
                a_q       <= A_i;
                b_q       <= B_i;
                c_q       <= C_i;
                bitsize_q <= bitSize_i;
            end
        end
    end

    // Operands are pure selects from the latched tiles; no arithmetic, full width.
    always_comb begin
        row_o    = '0;
        column_o = '0;
        for (int k = 0; k < K; k++) begin
            row_o[k]    = a_q[idx_i_o][k];
            column_o[k] = b_q[k][idx_j_o];
        end
        C_o = c_q[idx_i_o][idx_j_o];
    end

endmodule

// File: tb/tb_gemm_operand_feeder.sv
// Directed bench for gemm_operand_feeder: scoreboard queue of expected transfers,
// independent monitor, and timing checks on start/done/err/flush/reset.
module tb_gemm_operand_feeder;

  localparam int M  = 2;
  localparam int N  = 2;
  localparam int K  = 2;
  localparam int W  = 16;
  localparam int XW = 2 + 2 * K * W + 2 * W + 5;

  logic                         clk_i;
  logic                         rst_i;
  logic                         start_i;
  logic                         start_ready_o;
  logic [4:0]                   bitSize_i;
  logic [M-1:0][K-1:0][W-1:0]   A_i;
  logic [K-1:0][N-1:0][W-1:0]   B_i;
  logic [M-1:0][N-1:0][2*W-1:0] C_i;
  logic                         flush_i;
  logic [K-1:0][W-1:0]          row_o;
  logic [K-1:0][W-1:0]          column_o;
  logic [2*W-1:0]               C_o;
  logic [4:0]                   bitSize_o;
  logic [0:0]                   idx_i_o;
  logic [0:0]                   idx_j_o;
  logic                         valid_o;
  logic                         ready_i;
  logic                         done_o;
  logic                         err_o;
  logic [1:0]                   state_o;

  gemm_operand_feeder #(.M(M), .N(N), .K(K), .MAX_WIDTH(W)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .start_ready_o(start_ready_o),
    .bitSize_i    (bitSize_i),
    .A_i          (A_i),
    .B_i          (B_i),
    .C_i          (C_i),
    .flush_i      (flush_i),
    .row_o        (row_o),
    .column_o     (column_o),
    .C_o          (C_o),
    .bitSize_o    (bitSize_o),
    .idx_i_o      (idx_i_o),
    .idx_j_o      (idx_j_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .done_o       (done_o),
    .err_o        (err_o),
    .state_o      (state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [XW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int i, input int j, input int r0, input int r1,
                          input int c0, input int c1, input int cv, input int bs);
    exp_q.push_back({1'(i), 1'(j), 16'(r1), 16'(r0), 16'(c1), 16'(c0), 32'(cv), 5'(bs)});
  endtask

  // Hand-computed transfers of the basic tile, in issue order.
  task automatic push_basic(input int count);
    if (count > 0) push_exp(0, 0, 29, -13, -56, -98, 71, 4);
    if (count > 1) push_exp(0, 1, 29, -13,   5,   6,  0, 4);
    if (count > 2) push_exp(1, 0,  3,   4, -56, -98,  1, 4);
    if (count > 3) push_exp(1, 1,  3,   4,   5,   6,  2, 4);
  endtask

  // ---------------- monitor ----------------
  logic [XW-1:0] mon_cur, mon_held;
  logic          hold_pending = 1'b0;

  always @(negedge clk_i) begin
    mon_cur = {idx_i_o, idx_j_o, row_o, column_o, C_o, bitSize_o};
    if (rst_i) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        chk("stall_valid", valid_o, 1);
        chk("stall_stable", mon_cur, mon_held);
      end
      if (valid_o && ready_i) begin
        xfer_cnt++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_xfer: got %0h expected none", mon_cur);
        end else begin
          logic [XW-1:0] e;
          e = exp_q.pop_front();
          if (mon_cur !== e) begin
            n_fail++;
            $display("FAIL xfer: got %0h expected %0h", mon_cur, e);
          end
        end
      end
      hold_pending = valid_o && !ready_i && !flush_i;
      mon_held     = mon_cur;
      if (done_o) done_cnt++;
      if (err_o)  err_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_basic();
    A_i[0][0] = 16'(29);  A_i[0][1] = 16'(-13);
    A_i[1][0] = 16'(3);   A_i[1][1] = 16'(4);
    B_i[0][0] = 16'(-56); B_i[0][1] = 16'(5);
    B_i[1][0] = 16'(-98); B_i[1][1] = 16'(6);
    C_i[0][0] = 32'(71);  C_i[0][1] = 32'(0);
    C_i[1][0] = 32'(1);   C_i[1][1] = 32'(2);
  endtask

  task automatic do_start(input logic [4:0] bs);
    bitSize_i = bs;
    start_i   = 1'b1;
    tick();
    start_i   = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk_i);
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  task automatic check_done();
    @(negedge clk_i);
    chk("done_pulse", done_o, 1);
    chk("done_valid_low", valid_o, 0);
    @(negedge clk_i);
    chk("done_single", done_o, 0);
    chk("done_ready", start_ready_o, 1);
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_for_idx(input int wi, input int wj);
    int n;
    n = 0;
    while (!(valid_o && idx_i_o == 1'(wi) && idx_j_o == 1'(wj)) && n < 20) begin
      tick();
      n++;
    end
    chk("wait_idx", {valid_o, idx_i_o, idx_j_o}, {1'b1, 1'(wi), 1'(wj)});
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, valid_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_err"}, err_o, 0);
    chk({tag, "_idx"}, {idx_i_o, idx_j_o}, 0);
    chk({tag, "_bitsize"}, bitSize_o, 0);
    chk({tag, "_row"}, row_o, 0);
    chk({tag, "_col"}, column_o, 0);
    chk({tag, "_c"}, C_o, 0);
    chk({tag, "_start_ready"}, start_ready_o, 1);
    chk({tag, "_state"}, state_o, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d0, e0;
    rst_i = 1'b1; start_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
    bitSize_i = '0; A_i = '0; B_i = '0; C_i = '0;
    repeat (3) tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    check_all_zero("reset");
    tick();

    // Basic tile, ready held high.
    set_basic();
    push_basic(4);
    xfer_cnt = 0;
    do_start(5'd4);
    @(negedge clk_i);
    chk("first_valid_latency", valid_o, 1);
    wait_drain("basic_drain");
    check_done();
    chk("basic_xfer_count", xfer_cnt, 4);

    // Backpressure: ready low for 3 cycles at (0,1).
    push_basic(4);
    xfer_cnt = 0;
    do_start(5'd4);
    wait_for_idx(0, 1);
    ready_i = 1'b0;
    repeat (3) tick();
    chk("stall_busy", start_ready_o, 0);
    ready_i = 1'b1;
    wait_drain("bp_drain");
    check_done();
    chk("bp_xfer_count", xfer_cnt, 4);

    // Illegal precision: 5, then 32 (which wraps to 0 on a 5-bit port).
    e0 = err_cnt;
    do_start(5'd5);
    @(negedge clk_i);
    chk("err5_pulse", err_o, 1);
    chk("err5_valid", valid_o, 0);
    chk("err5_ready", start_ready_o, 1);
    @(negedge clk_i);
    chk("err5_single", err_o, 0);
    tick();
    do_start(5'(32));
    @(negedge clk_i);
    chk("err32_pulse", err_o, 1);
    chk("err32_valid", valid_o, 0);
    chk("err32_bitsize_kept", bitSize_o, 4);
    @(negedge clk_i);
    chk("err32_single", err_o, 0);
    chk("err_count", err_cnt - e0, 2);
    tick();

    // Start while busy is ignored.
    e0 = err_cnt;
    push_basic(4);
    do_start(5'd4);
    A_i[0][0] = 16'(111); A_i[1][1] = 16'(-222); C_i[0][1] = 32'(999);
    bitSize_i = 5'd5;
    start_i   = 1'b1;
    @(negedge clk_i);
    chk("busy_not_ready", start_ready_o, 0);
    tick();
    start_i = 1'b0;
    @(negedge clk_i);
    chk("busy_no_err", err_o, 0);
    wait_drain("busy_drain");
    check_done();
    chk("busy_err_count", err_cnt - e0, 0);
    set_basic();

    // Flush after two transfers.
    push_basic(2);
    xfer_cnt = 0;
    d0 = done_cnt;
    do_start(5'd4);
    wait_for_idx(1, 0);
    ready_i = 1'b0;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk_i);
    chk("flush_valid", valid_o, 0);
    chk("flush_idx", {idx_i_o, idx_j_o}, 0);
    chk("flush_ready", start_ready_o, 1);
    repeat (3) tick();
    chk("flush_no_done", done_cnt - d0, 0);
    chk("flush_xfer_count", xfer_cnt, 2);
    push_basic(4);
    do_start(5'd4);
    wait_drain("after_flush_drain");
    check_done();

    // Reset in the middle of a tile.
    push_basic(4);
    do_start(5'd4);
    wait_for_idx(0, 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    check_all_zero("midreset");
    exp_q.delete();
    tick();
    push_basic(4);
    do_start(5'd4);
    wait_drain("after_reset_drain");
    check_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gemm_operand_feeder.md
Name: gemm_operand_feeder

Overview:
- Upstream stage of seq_mult_adder.
- Latches one M x K A tile, one K x N B tile and one M x N C tile, plus the precision setting, on a start handshake.
- Then issues one output element's operands per valid/ready transfer (A row i, B column j, C[i][j]) in row-major (i, j) order.
- Signals completion with a one-cycle done pulse.

Parameters:
- M, 2, rows of A / C tile
- N, 2, columns of B / C tile
- K, 2, dot-product length; equals seq_mult_adder K
- MAX_WIDTH, 16, operand element width in bits (signed)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- start_i  in  1  request to load tiles and begin
- start_ready_o  out  1  high only in IDLE
- bitSize_i  in  5  requested precision, sampled on start
- A_i  in  [M][K] x MAX_WIDTH signed  A tile
- B_i  in  [K][N] x MAX_WIDTH signed  B tile
- C_i  in  [M][N] x 2*MAX_WIDTH signed  accumulator seed tile
- flush_i  in  1  abort the current tile
- row_o  out  [K] x MAX_WIDTH signed  A[i][0..K-1]
- column_o  out  [K] x MAX_WIDTH signed  B[0..K-1][j]
- C_o  out  2*MAX_WIDTH signed  C[i][j]
- bitSize_o  out  5  latched precision
- idx_i_o  out  max(1,$clog2(M))  current i
- idx_j_o  out  max(1,$clog2(N))  current j
- valid_o  out  1  operands valid
- ready_i  in  1  consumer ready (seq_mult_adder ready_in)
- done_o  out  1  one-cycle pulse after the last transfer
- err_o  out  1  one-cycle pulse when a start is rejected

Behaviour:
- FSM states: IDLE, ISSUE, DONE. All state is synchronous to clk_i.
- Reset (rst_i high at a clock edge), takes priority over everything including mid-tile:
  - FSM goes to IDLE.
  - valid_o, done_o, err_o = 0; idx_i_o, idx_j_o = 0; bitSize_o = 0.
  - Tile registers, row_o, column_o and C_o = 0.
- IDLE:
  - start_ready_o = 1.
  - Start fires when start_i && start_ready_o.
  - Legal bitSize_i values: 2, 4, 8, 16, each <= MAX_WIDTH.
  - Start with a legal bitSize_i: latch A, B, C and bitSize; set i = j = 0; next state ISSUE.
  - Start with an illegal bitSize_i: err_o = 1 for the next cycle; remain in IDLE; tile registers unchanged.
- ISSUE:
  - valid_o = 1 from the first cycle after start. Latency from start to first valid = 1 cycle.
  - Outputs are driven combinationally from the registered tiles indexed by (i, j).
  - Outputs are stable while valid_o && !ready_i; valid_o never drops without a transfer.
  - Transfer = valid_o && ready_i. On a transfer:
    - j < N-1: j++.
    - j = N-1 and i < M-1: j = 0, i++.
    - i = M-1 and j = N-1: next state DONE.
  - With ready_i held high, one transfer per cycle; total M*N transfers.
- DONE: valid_o = 0; done_o = 1 for exactly this cycle; next state IDLE.
- A start_i asserted outside IDLE is ignored (start_ready_o = 0); no error pulse.
- flush_i in ISSUE or DONE: next state IDLE, valid_o = 0 next cycle, no done_o pulse, i = j = 0. A transfer coinciding with flush_i is still counted by the consumer.
- flush_i in IDLE has no effect; if start_i fires in the same cycle, start wins.
- M = 1 or N = 1: index counters hold at 0 on their own dimension; wrap logic still holds.
- No arithmetic is performed; all values pass through at full width without truncation.

Decomposition:
- Shared package swirl_pkg:
  - fsm state enum: feeder_state_e.
  - Legal bitSize constants: BITSIZE_2/4/8/16.
  - Function is_legal_bitsize(bitSize, max_width).
- One natural sub-module: tile_index_counter. Row-major (i, j) counter with advance input, last output and clear input; reused by the downstream result collector.

Test Plan:
- Basic tile:
  - Stimulus: M=N=K=2, A={{29,-13},{3,4}}, B={{-56,5},{-98,6}}, C={{71,0},{1,2}}, bitSize=4, ready_i=1.
  - Required: transfers in order (0,0) row {29,-13} col {-56,-98} C 71; (0,1) col {5,6} C 0; (1,0) row {3,4} C 1; (1,1) C 2.
  - Required: done_o exactly 1 cycle after the 4th transfer.
- Backpressure:
  - Stimulus: ready_i low for 3 cycles at (0,1).
  - Required: valid_o stays high and outputs stay constant; exactly 4 transfers total; no duplicates or skipped elements.
- Illegal precision:
  - Stimulus: start with bitSize=5, then with bitSize=32 at MAX_WIDTH=16.
  - Required: err_o pulses once each; valid_o stays 0; start_ready_o stays 1.
- Busy start:
  - Stimulus: start_i asserted during ISSUE with different A.
  - Required: ignored; the original tile completes; no err_o.
- Flush:
  - Stimulus: flush_i after 2 transfers.
  - Required: valid_o = 0 next cycle; no done_o; a new start then issues from (0,0).
- Reset mid-tile:
  - Stimulus: rst_i high 1 cycle during ISSUE.
  - Required: all outputs 0 next cycle; start_ready_o = 1; FSM in IDLE.
